// File: rtl/fxp_pkg.sv
// Shared types and constants for the signed fixed-point sequential multiplier.
// WORD_SIZE defaults to 8 if the configuration has not already defined it.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package fxp_pkg;
  localparam int W      = `WORD_SIZE;
  localparam int PROD_W = 2 * W;
  localparam int QW     = 4;
  localparam int QSUM_W = 5;

  localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAXNEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/fxp_mag_mult.sv
// Unsigned W x W shift-add core: W steps after start; done/prod are valid during the last step.
// No backpressure; the caller must capture prod while done is high.
module fxp_mag_mult
  import fxp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              done,
  output logic [PROD_W-1:0] prod
);
  localparam int CNT_W = $clog2(W);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [W-1:0]      mplier;

  // prod is the accumulator after the current step, so the caller sees the
  // final product on the same edge that completes the last step.
  assign prod = mplier[0] ? acc + mcand : acc;
  assign done = busy && (cnt == CNT_W'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/fxp_seq_mult.sv
// Signed fixed-point multiplier with sign-bit normalisation; result W+s+1 cycles after accept,
// held until out_ready. WORD_SIZE sets the width; FXP_MULT_ROUND_EN selects round half-up over floor.
module fxp_seq_mult
  import fxp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  DataA,
  input  logic [W-1:0]  DataB,
  input  logic [QW-1:0] QI_A,
  input  logic [QW-1:0] QF_A,
  input  logic [QW-1:0] QI_B,
  input  logic [QW-1:0] QF_B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Product,
  output logic [QW-1:0] QI_out,
  output logic [QW-1:0] QF_out,
  output logic          ovf
);
  state_t              state;
  logic                sign;
  logic [QSUM_W-1:0]   qir;
  logic [PROD_W-1:0]   raw;
  logic                start;
  logic [W-1:0]        mag_a;
  logic [W-1:0]        mag_b;
  logic                core_done;
  logic [PROD_W-1:0]   core_prod;
  logic [W-1:0]        hi;
  logic [W-1:0]        res_prod;
  logic                res_ovf;
  logic                sat;

  assign start = in_valid && in_ready;
  // The most negative operand maps to the unsigned value 2^(W-1), which still fits in W bits.
  assign mag_a = DataA[W-1] ? -DataA : DataA;
  assign mag_b = DataB[W-1] ? -DataB : DataB;

  always_comb begin
    if (in_valid) begin
      assert (int'(QI_A) + int'(QF_A) == W && int'(QI_B) + int'(QF_B) == W);
    end
  end

  fxp_mag_mult u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (mag_a),
    .b     (mag_b),
    .done  (core_done),
    .prod  (core_prod)
  );

  assign hi  = raw[PROD_W-1 -: W];
  assign sat = qir > QSUM_W'(W);

  always_comb begin
    res_prod = hi;
    res_ovf  = 1'b0;
`ifdef FXP_MULT_ROUND_EN
    // Only a positive value can carry out of range when rounding up.
    if (raw[W-1]) begin
      if (hi == MAXPOS) res_ovf = 1'b1;
      else              res_prod = hi + 1'b1;
    end
`endif
    if (sat) begin
      res_ovf  = 1'b1;
      res_prod = sign ? MAXNEG : MAXPOS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Product   <= '0;
      QI_out    <= '0;
      QF_out    <= '0;
      ovf       <= 1'b0;
      sign      <= 1'b0;
      qir       <= '0;
      raw       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign     <= DataA[W-1] ^ DataB[W-1];
            qir      <= QSUM_W'(QI_A) + QSUM_W'(QI_B);
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          if (core_done) begin
            raw   <= sign ? -core_prod : core_prod;
            state <= NORM;
          end
        end
        NORM: begin
          // qir tracks QIp - s directly; a redundant sign bit is dropped per cycle.
          if (raw[PROD_W-1] == raw[PROD_W-2] && qir > QSUM_W'(1)) begin
            raw <= raw << 1;
            qir <= qir - 1'b1;
          end else begin
            Product   <= res_prod;
            ovf       <= res_ovf;
            if (sat) begin
              QI_out <= QW'(W);
              QF_out <= '0;
            end else begin
              QI_out <= qir[QW-1:0];
              QF_out <= QW'(W) - qir[QW-1:0];
            end
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_seq_mult.sv
// Bench for fxp_seq_mult at WORD_SIZE=8: vector table plus back-pressure and mid-operation reset sequences.
module tb_fxp_seq_mult;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] DataA = '0;
  logic [TW-1:0] DataB = '0;
  logic [3:0]    QI_A = 4'd4, QF_A = 4'd4, QI_B = 4'd4, QF_B = 4'd4;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [TW-1:0] Product;
  logic [3:0]    QI_out, QF_out;
  logic          ovf;

  fxp_seq_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DataA     (DataA),
    .DataB     (DataB),
    .QI_A      (QI_A),
    .QF_A      (QF_A),
    .QI_B      (QI_B),
    .QF_B      (QF_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Product   (Product),
    .QI_out    (QI_out),
    .QF_out    (QF_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] qa;
    logic [3:0] qb;
    logic [7:0] prod;
    logic [3:0] qi;
    logic       ovf;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] prod;
    logic [3:0] qi;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

`ifdef FXP_MULT_ROUND_EN
  localparam logic [7:0] P_RND  = 8'h02;
  localparam logic [7:0] P_NEG  = 8'h00;
  localparam logic       O_SATR = 1'b1;
`else
  localparam logic [7:0] P_RND  = 8'h01;
  localparam logic [7:0] P_NEG  = 8'hFF;
  localparam logic       O_SATR = 1'b0;
`endif

  vec_t vecs[10];
  exp_t sb[$];
  exp_t e;
  logic seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: latency on first sight of out_valid, fields on handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
        else                chk("latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("product", Product, e.prod);
          chk("qi_out", QI_out, e.qi);
          chk("qf_out", QF_out, 8 - e.qi);
          chk("ovf", ovf, e.ovf);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      return;
    end
    DataA = v.a;  DataB = v.b;
    QI_A = v.qa;  QF_A = 4'(8 - v.qa);
    QI_B = v.qb;  QF_B = 4'(8 - v.qb);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back('{v.prod, v.qi, v.ovf, v.lat, cyc});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_product"}, Product, 0);
    chk({tag, "_qi_out"}, QI_out, 0);
    chk({tag, "_qf_out"}, QF_out, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int hs_cyc;
    int n;
    logic [7:0] hp;
    logic [3:0] hqi, hqf;

    //         a      b      qa    qb    prod   qi    ovf   lat
    vecs[0] = '{8'h40, 8'h40, 4'd2, 4'd2, 8'h40, 4'd2, 1'b0, 11};  // 1.0 x 1.0
    vecs[1] = '{8'hC0, 8'h40, 4'd2, 4'd2, 8'h80, 4'd1, 1'b0, 12};  // -1.0 x 1.0
    vecs[2] = '{8'h7F, 8'h7F, 4'd8, 4'd8, 8'h7F, 4'd8, 1'b1, 10};  // integer overflow
    vecs[3] = '{8'h03, 8'h43, 4'd1, 4'd1, P_RND, 4'd1, 1'b0, 10};  // rounding bit set
    vecs[4] = '{8'h00, 8'h55, 4'd4, 4'd4, 8'h00, 4'd1, 1'b0, 16};  // zero product
    vecs[5] = '{8'h80, 8'h7F, 4'd8, 4'd8, 8'h80, 4'd8, 1'b1, 10};  // negative saturation
    vecs[6] = '{8'h80, 8'h80, 4'd1, 4'd1, 8'h40, 4'd2, 1'b0, 9};   // -1 x -1, no shift
    vecs[7] = '{8'hA0, 8'h30, 4'd4, 4'd3, 8'hB8, 4'd5, 1'b0, 11};  // -6.0 x 1.5
    vecs[8] = '{8'hFF, 8'h01, 4'd1, 4'd1, P_NEG, 4'd1, 1'b0, 10};  // tiny negative
    vecs[9] = '{8'h60, 8'h55, 4'd2, 4'd2, 8'h7F, 4'd2, O_SATR, 11}; // round-up carry

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(vecs[i]);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(vecs[0]);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    hp = Product; hqi = QI_out; hqf = QF_out;
    chk("bp_product", hp, 8'h40);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_product", Product, hp);
      chk("bp_hold_qi", QI_out, hqi);
      chk("bp_hold_qf", QF_out, hqf);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    send(vecs[1]);
    if (sb.size() > 0) chk("reaccept_gap", sb[$].acc - hs_cyc, 1);
    else               chk("reaccept_push", sb.size(), 1);
    drain();

    // Reset in the 4th MUL cycle aborts with no output.
    send(vecs[0]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", Product, 0);
    chk("midrst_qi_out", QI_out, 0);
    sb.delete();
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_output", out_valid, 0);
    end
    send(vecs[0]);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
